// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Receives a framed byte stream and writes it into instruction memory as
// little-endian 32-bit words, starting at address 0. The core is held in reset
// until the whole image has arrived and its checksum matches.
// Stream frame: N (2 bytes, LE), 4*N data bytes, XOR checksum of all prior bytes.
//
// Ports:
//   i_clk, i_arstn     clock (rising edge), asynchronous active-low reset
//   i_restart          synchronous pulse: abort/finish the load and re-arm
//   i_rxValid/i_rxData byte stream input; accepted when i_rxValid && o_rxReady
//   o_rxReady          loader can take a byte (any state except DONE/ERROR)
//   o_memWriteEn       one-cycle write strobe to instruction memory
//   o_memAddress       word-aligned byte address of the write (held between writes)
//   o_memWriteData     word to write (held between writes)
//   o_coreSrst         synchronous reset to the core, released only in DONE
//   o_done             image loaded with a matching checksum
//   o_error            length out of range or checksum mismatch
module imem_loader #(
    parameter int MEM_WORDS = 64
) (
    input  logic        i_clk,
    input  logic        i_arstn,
    input  logic        i_restart,
    input  logic        i_rxValid,
    input  logic [7:0]  i_rxData,
    output logic        o_rxReady,
    output logic        o_memWriteEn,
    output logic [31:0] o_memAddress,
    output logic [31:0] o_memWriteData,
    output logic        o_coreSrst,
    output logic        o_done,
    output logic        o_error
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] index_q, index_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] len_q, len_d;
    logic [23:0] word_q, word_d;      // bytes 0..2 of the word being assembled
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic [15:0] len_full;

    assign o_rxReady      = (state_q != S_DONE) && (state_q != S_ERROR);
    assign o_done         = (state_q == S_DONE);
    assign o_error        = (state_q == S_ERROR);
    assign o_coreSrst     = (state_q != S_DONE);
    assign o_memWriteEn   = we_q;
    assign o_memAddress   = addr_q;
    assign o_memWriteData = wdata_q;

    assign accept   = i_rxValid && o_rxReady;
    assign len_full = {i_rxData, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        csum_d     = csum_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        // Restart wins over a byte offered in the same cycle; that byte is lost.
        if (i_restart) begin
            state_d    = S_LEN_LO;
            csum_d     = 8'd0;
            index_d    = 16'd0;
            byte_cnt_d = 2'd0;
        end else if (accept) begin
            // Folding the checksum byte itself in is harmless: CHECK always exits.
            csum_d = csum_q ^ i_rxData;
            case (state_q)
                S_LEN_LO: begin
                    len_d[7:0] = i_rxData;
                    state_d    = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d = len_full;
                    if ({16'd0, len_full} > MEM_WORDS_L) begin
                        state_d = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = i_rxData;
                        2'd1: word_d[15:8]  = i_rxData;
                        2'd2: word_d[23:16] = i_rxData;
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = {14'd0, index_q, 2'b00};
                            wdata_d = {i_rxData, word_q};
                            index_d = index_q + 16'd1;
                            if (index_q + 16'd1 == len_q) begin
                                state_d = S_CHECK;
                            end
                        end
                    endcase
                end
                S_CHECK: begin
                    state_d = (i_rxData == csum_q) ? S_DONE : S_ERROR;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q    <= S_LEN_LO;
            csum_q     <= 8'd0;
            index_q    <= 16'd0;
            byte_cnt_q <= 2'd0;
            len_q      <= 16'd0;
            word_q     <= 24'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            csum_q     <= csum_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_arstn;
    logic        i_restart;
    logic        i_rxValid;
    logic [7:0]  i_rxData;
    logic        o_rxReady;
    logic        o_memWriteEn;
    logic [31:0] o_memAddress;
    logic [31:0] o_memWriteData;
    logic        o_coreSrst;
    logic        o_done;
    logic        o_error;

    imem_loader #(.MEM_WORDS(64)) dut (
        .i_clk          (i_clk),
        .i_arstn        (i_arstn),
        .i_restart      (i_restart),
        .i_rxValid      (i_rxValid),
        .i_rxData       (i_rxData),
        .o_rxReady      (o_rxReady),
        .o_memWriteEn   (o_memWriteEn),
        .o_memAddress   (o_memAddress),
        .o_memWriteData (o_memWriteData),
        .o_coreSrst     (o_coreSrst),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rs;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [31:0] a;
        logic [31:0] w;
        logic        srst;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t        vecs[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] ha = 32'd0;
    logic [31:0] hw = 32'd0;
    logic [7:0]  img_ok[$]  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                                8'h93, 8'h05, 8'hA0, 8'h00, 8'h72};
    logic [7:0]  img_part[$] = '{8'h02, 8'h00, 8'h13, 8'h05};

    function automatic void add(input logic rs, input logic v, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [31:0] a,
                                input logic [31:0] w, input logic srst,
                                input logic dn, input logic er);
        vec_t t;
        t.rs = rs; t.v = v; t.d = d; t.rdy = rdy; t.we = we;
        t.a = a; t.w = w; t.srst = srst; t.dn = dn; t.er = er;
        vecs.push_back(t);
    endfunction

    // Scenario-1 image (2 words) with a chosen checksum byte.
    task automatic add_img(input logic [7:0] last, input logic good,
                           inout logic [31:0] a, inout logic [31:0] w);
        logic [7:0] b[10];
        logic       we;
        b = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        for (int i = 0; i < 10; i++) begin
            we = (i == 5) || (i == 9);
            if (i == 5) begin a = 32'h0; w = 32'h0050_0513; end
            if (i == 9) begin a = 32'h4; w = 32'h00A0_0593; end
            add(1'b0, 1'b1, b[i], 1'b1, we, a, w, 1'b1, 1'b0, 1'b0);
        end
        add(1'b0, 1'b1, last, 1'b0, 1'b0, a, w, !good, good, !good);
    endtask

    function automatic logic [68:0] outs();
        return {o_rxReady, o_memWriteEn, o_memAddress, o_memWriteData,
                o_coreSrst, o_done, o_error};
    endfunction

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic v, input logic [7:0] d);
        i_restart = rs;
        i_rxValid = v;
        i_rxData  = d;
        @(posedge i_clk);
        #1;
        if (o_memWriteEn) begin
            wr_a.push_back(o_memAddress);
            wr_d.push_back(o_memWriteData);
        end
    endtask

    task automatic send(input logic [7:0] bytes[$], input logic gaps);
        foreach (bytes[i]) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 8'($urandom));
            end
            step(1'b0, 1'b1, bytes[i]);
        end
    endtask

    task automatic check_writes(input string name, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1);
        check({name, "_nwr"}, 69'(wr_a.size()), 69'd2);
        while (wr_a.size() < 2) begin
            wr_a.push_back('x);
            wr_d.push_back('x);
        end
        check({name, "_wr0"}, 69'({wr_a[0], wr_d[0]}), 69'({a0, d0}));
        check({name, "_wr1"}, 69'({wr_a[1], wr_d[1]}), 69'({a1, d1}));
    endtask

    initial begin
        i_arstn   = 1'b0;
        i_restart = 1'b0;
        i_rxValid = 1'b0;
        i_rxData  = 8'h00;

        // Good image, then DONE ignores further bytes.
        add_img(8'h72, 1'b1, ha, hw);
        add(0, 1, 8'h55, 0, 0, ha, hw, 0, 1, 0);
        add(1, 0, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        // Bad checksum: writes still land, then ERROR holds.
        add_img(8'h73, 1'b0, ha, hw);
        add(0, 1, 8'h11, 0, 0, ha, hw, 1, 0, 1);
        add(1, 0, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        // N = 65 > MEM_WORDS: error after the high byte, no write.
        add(0, 1, 8'h41, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, ha, hw, 1, 0, 1);
        add(0, 1, 8'h00, 0, 0, ha, hw, 1, 0, 1);
        add(1, 0, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        // N = MEM_WORDS is legal.
        add(0, 1, 8'h40, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        add(1, 0, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        // Empty image, then restart with a concurrent byte that must be dropped.
        add(0, 1, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, ha, hw, 0, 1, 0);
        add(1, 1, 8'hAA, 1, 0, ha, hw, 1, 0, 0);
        // Partial word, restart coincides with the 4th byte: no write.
        add(0, 1, 8'h02, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h13, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h05, 1, 0, ha, hw, 1, 0, 0);
        add(0, 1, 8'h50, 1, 0, ha, hw, 1, 0, 0);
        add(1, 1, 8'h00, 1, 0, ha, hw, 1, 0, 0);
        add_img(8'h72, 1'b1, ha, hw);

        #1;
        check("reset", outs(), {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
        @(posedge i_clk);
        #1;
        i_arstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rs, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].rdy, vecs[i].we, vecs[i].a, vecs[i].w,
                   vecs[i].srst, vecs[i].dn, vecs[i].er});
        end

        // Valid gaps with random data while invalid.
        step(1'b1, 1'b0, 8'h00);
        wr_a.delete();
        wr_d.delete();
        send(img_ok, 1'b1);
        check_writes("gaps", 32'h0, 32'h0050_0513, 32'h4, 32'h00A0_0593);
        check("gaps_flags", outs(), {1'b0, 1'b0, 32'h4, 32'h00A0_0593, 1'b0, 1'b1, 1'b0});

        // Asynchronous reset mid-load, then a full load.
        step(1'b1, 1'b0, 8'h00);
        send(img_part, 1'b0);
        #2;
        i_arstn = 1'b0;
        #1;
        check("arst_now", outs(), {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});
        i_rxValid = 1'b0;
        @(posedge i_clk);
        #1;
        i_arstn = 1'b1;
        wr_a.delete();
        wr_d.delete();
        send(img_ok, 1'b0);
        check_writes("arst", 32'h0, 32'h0050_0513, 32'h4, 32'h00A0_0593);
        check("arst_flags", outs(), {1'b0, 1'b0, 32'h4, 32'h00A0_0593, 1'b0, 1'b1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
